// File: rtl/template_pkg.sv
// Shared types for the template scheduler: FSM state encoding, in-flight tag format
// and a one-hot to index encoder.
package template_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned MAX_NUM_REQ        = 16;
  localparam int unsigned TAG_ID_W           = $clog2(MAX_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    DRAIN = 2'd2
  } template_sched_state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } sched_tag_t;

  // OR-reduction encoder; the input is one-hot or zero by construction.
  function automatic logic [TAG_ID_W-1:0] onehot_idx(input logic [MAX_NUM_REQ-1:0] oh);
    logic [TAG_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_NUM_REQ); i++) begin
      if (oh[i]) idx = idx | TAG_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/template_rr_arbiter.sv
// Combinational round-robin arbiter with burst hold: the last winner keeps the grant
// while hold_i allows it, otherwise the search starts after (or at) the pointer.
module template_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  input  logic                       start_at_ptr_i,
  input  logic                       hold_i,
  output logic [NUM_REQ-1:0]         grant_o
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  logic          found;
  logic [PW-1:0] sel;

  // NOTE: combinational logic uses blocking assignments with every output defaulted
  // first, so the search reads as a priority chain and no latch can be inferred.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sel     = '0;
    if (hold_i && req_i[ptr_i]) begin
      grant_o[ptr_i] = 1'b1;
    end else begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        sel = PW'((int'(ptr_i) + (start_at_ptr_i ? 0 : 1) + k) % int'(NUM_REQ));
        if (!found && req_i[sel]) begin
          grant_o[sel] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/template_scheduler.sv
// Round-robin scheduler sharing one fixed-latency datapath between NUM_REQ requesters.
// Optional per-requester saturating grant counters: define TEMPLATE_SCHEDULER_STATS_EN.
module template_scheduler
  import template_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DP_LATENCY = 3,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         dp_input_data,
  output logic                          dp_input_valid,
  input  logic [DATA_WIDTH-1:0]         dp_output_data,
  output logic                          resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id,
  output logic [DATA_WIDTH-1:0]         resp_data,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic                          busy
`ifdef TEMPLATE_SCHEDULER_STATS_EN
  ,
  input  logic                          stats_clear,
  output logic [NUM_REQ*16-1:0]         grant_count
`endif
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned BW   = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  template_sched_state_t state_q;
  logic                  flush_done_q;
  logic [ID_W-1:0]       ptr_q;
  logic [BW-1:0]         burst_q;
  logic [DATA_WIDTH-1:0] dp_data_q;
  sched_tag_t            in_tag_q;
  sched_tag_t            tag_q [DP_LATENCY];
  logic                  resp_valid_q;
  logic [ID_W-1:0]       resp_id_q;
  logic [DATA_WIDTH-1:0] resp_data_q;

  logic [NUM_REQ-1:0]    grant;
  logic                  accept;
  logic [TAG_ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]       acc_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  busy_c;

  template_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i          (req_valid),
    .ptr_i          (ptr_q),
    .start_at_ptr_i (burst_q == '0),
    .hold_i         ((burst_q != '0) && (burst_q < BURST_MAX)),
    .grant_o        (grant)
  );

  assign req_ready = (state_q == ARB) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign grant_idx = onehot_idx(MAX_NUM_REQ'(grant));
  assign acc_idx   = grant_idx[ID_W-1:0];

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    busy_c = in_tag_q.valid;
    for (int j = 0; j < int'(DP_LATENCY); j++) busy_c = busy_c | tag_q[j].valid;
  end

  // Control FSM; flush_done is registered so it rises the cycle after busy falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      flush_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    if (flush_req) state_q <= DRAIN;
                 else if (|req_valid) state_q <= ARB;
        ARB:     if (flush_req) state_q <= DRAIN;
                 else if (!(|req_valid) && !busy_c) state_q <= IDLE;
        DRAIN:   if (!flush_req) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      flush_done_q <= (state_q == DRAIN) && flush_req && !busy_c;
    end
  end

  // The input tag register travels with dp_input_valid; the burst count saturates at
  // MAX_BURST when a lone requester keeps winning after forced rotation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_data_q <= '0;
      in_tag_q  <= '0;
      ptr_q     <= '0;
      burst_q   <= '0;
    end else if (accept) begin
      dp_data_q      <= sel_data;
      in_tag_q.valid <= 1'b1;
      in_tag_q.id    <= grant_idx;
      ptr_q          <= acc_idx;
      if (acc_idx == ptr_q) burst_q <= (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
      else                  burst_q <= BW'(1);
    end else begin
      in_tag_q.valid <= 1'b0;
    end
  end

  // NOTE: the tag array is reset, unlike a plain data memory, because a stale valid
  // bit surviving reset would emit a response for a word that was dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < int'(DP_LATENCY); j++) tag_q[j] <= '0;
    end else begin
      tag_q[0] <= in_tag_q;
      for (int j = 1; j < int'(DP_LATENCY); j++) tag_q[j] <= tag_q[j-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= tag_q[DP_LATENCY-1].valid;
      if (tag_q[DP_LATENCY-1].valid) begin
        resp_id_q   <= tag_q[DP_LATENCY-1].id[ID_W-1:0];
        resp_data_q <= dp_output_data;
      end
    end
  end

`ifdef TEMPLATE_SCHEDULER_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REQ); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (stats_clear)                                   cnt_q[i] <= '0;
        else if (accept && grant[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_cnt
    assign grant_count[g*16 +: 16] = cnt_q[g];
  end
`endif

  assign dp_input_data  = dp_data_q;
  assign dp_input_valid = in_tag_q.valid;
  assign resp_valid     = resp_valid_q;
  assign resp_id        = resp_id_q;
  assign resp_data      = resp_data_q;
  assign flush_done     = flush_done_q;
  assign busy           = busy_c;

endmodule
